// File: rtl/imm_pkg.sv
// Shared types and RISC-V opcode constants for the immediate decode stage.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_CSR_Z = 3'd7
    } imm_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Valid/ready bus of the immediate decode stage: instruction in, decoded beat out.
interface imm_decode_stage_if #(parameter int XLEN = 32);
    import imm_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    imm_type_e       out_imm_type;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type, out_illegal
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate extractor: class code, XLEN-wide immediate, illegal flag.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit EN_CSR_ZIMM = 1'b1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] shamt_w, shamt_x, zimm;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u   = {instr[31:12], 12'b0};
    assign imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign shamt_w = {27'b0, instr[24:20]};
    assign shamt_x = (XLEN == 64) ? {26'b0, instr[25:20]} : shamt_w;
    assign zimm    = {27'b0, instr[19:15]};

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] zext(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    // Any opcode not listed, including instr[1:0] != 2'b11, falls to default.
    always_comb begin
        imm      = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                imm_type = IMM_I;
                imm      = sext(imm_i);
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm_type = IMM_SHAMT;
                    imm      = zext(shamt_x);
                end else begin
                    imm_type = IMM_I;
                    imm      = sext(imm_i);
                end
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        imm_type = IMM_SHAMT;
                        imm      = zext(shamt_w);
                    end else begin
                        imm_type = IMM_I;
                        imm      = sext(imm_i);
                    end
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                imm      = sext(imm_s);
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                imm      = sext(imm_b);
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_type = IMM_U;
                imm      = sext(imm_u);
            end
            OPC_JAL: begin
                imm_type = IMM_J;
                imm      = sext(imm_j);
            end
            OPC_SYSTEM: begin
                if (EN_CSR_ZIMM && funct3[2]) begin
                    imm_type = IMM_CSR_Z;
                    imm      = zext(zimm);
                end
            end
            OPC_OP, OPC_MISC_MEM: begin
                imm_type = IMM_NONE;
            end
            OPC_OP_32: begin
                illegal = (XLEN != 64);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage: decode at input, two-entry main/skid buffer on output.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit EN_CSR_ZIMM = 1'b1
) (
    input logic                clk,
    input logic                rst,
    imm_decode_stage_if.slave  bus
);

    occ_state_e      state;
    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;
    logic            dec_illegal;
    logic            accept;
    logic            emit;

    logic [31:0]     m_instr, s_instr;
    logic [XLEN-1:0] m_pc, s_pc, m_imm, s_imm;
    imm_type_e       m_type, s_type;
    logic            m_illegal, s_illegal;

    imm_decode #(
        .XLEN        (XLEN),
        .EN_CSR_ZIMM (EN_CSR_ZIMM)
    ) u_decode (
        .instr    (bus.in_instr),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    assign bus.in_ready     = (state != ST_TWO);
    assign bus.out_valid    = (state != ST_EMPTY);
    assign accept           = bus.in_valid & bus.in_ready;
    assign emit             = bus.out_valid & bus.out_ready;
    assign bus.out_instr    = m_instr;
    assign bus.out_pc       = m_pc;
    assign bus.out_imm      = m_imm;
    assign bus.out_imm_type = m_type;
    assign bus.out_illegal  = m_illegal;

    // M always holds the oldest beat; S only fills while M is stalled downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            m_instr   <= '0;
            m_pc      <= '0;
            m_imm     <= '0;
            m_type    <= IMM_NONE;
            m_illegal <= 1'b0;
            s_instr   <= '0;
            s_pc      <= '0;
            s_imm     <= '0;
            s_type    <= IMM_NONE;
            s_illegal <= 1'b0;
        end else if (bus.flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        m_instr   <= bus.in_instr;
                        m_pc      <= bus.in_pc;
                        m_imm     <= dec_imm;
                        m_type    <= dec_type;
                        m_illegal <= dec_illegal;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !emit) begin
                        s_instr   <= bus.in_instr;
                        s_pc      <= bus.in_pc;
                        s_imm     <= dec_imm;
                        s_type    <= dec_type;
                        s_illegal <= dec_illegal;
                        state     <= ST_TWO;
                    end else if (accept && emit) begin
                        m_instr   <= bus.in_instr;
                        m_pc      <= bus.in_pc;
                        m_imm     <= dec_imm;
                        m_type    <= dec_type;
                        m_illegal <= dec_illegal;
                    end else if (emit) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (emit) begin
                        m_instr   <= s_instr;
                        m_pc      <= s_pc;
                        m_imm     <= s_imm;
                        m_type    <= s_type;
                        m_illegal <= s_illegal;
                        state     <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule
